// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix multiplier.
// Optional macro: SYSTOLIC_SAT_EN (saturating accumulation).
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN
    } state_e;

    // Product of two DATA_W elements summed over N terms.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    // Clamp v to the w-bit range of the selected signedness.
    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] v,
        input int                 w,
        input logic               sgn
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (sgn) begin
            hi = (64'sd1 <<< (w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (w - 1));
        end else begin
            hi = (64'sd1 <<< w) - 64'sd1;
            lo = 64'sd0;
        end
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One MAC cell: forwards a right and b down, accumulates a*b.
// Optional macro: SYSTOLIC_SAT_EN (clamped accumulator + flag).
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
`ifdef SYSTOLIC_SAT_EN
    output logic              sat_o,
`endif
    output logic [ACC_W-1:0]  acc_o
);

    localparam int P_W = 2 * DATA_W + 2;

    logic [DATA_W-1:0]       a_q;
    logic [DATA_W-1:0]       b_q;
    logic [ACC_W-1:0]        acc_q;
    logic [ACC_W-1:0]        acc_d;
    logic signed [DATA_W:0]  a_x;
    logic signed [DATA_W:0]  b_x;
    logic signed [P_W-1:0]   prod;

    // Extend operands by one bit so one signed multiply serves both modes.
    always_comb begin
        a_x  = {mode_i & a_i[DATA_W-1], a_i};
        b_x  = {mode_i & b_i[DATA_W-1], b_i};
        prod = P_W'(a_x) * P_W'(b_x);
    end

`ifdef SYSTOLIC_SAT_EN
    logic               sat_q;
    logic               sat_d;
    logic signed [63:0] acc_x;
    logic signed [63:0] sum_x;
    logic signed [63:0] clamp_x;

    // Exact sum in a wide domain, then clamp; the flag is sticky per job.
    always_comb begin
        acc_x   = mode_i ? 64'(signed'(acc_q)) : 64'(acc_q);
        sum_x   = acc_x + 64'(prod);
        clamp_x = sat_clamp(sum_x, ACC_W, mode_i);
        acc_d   = clamp_x[ACC_W-1:0];
        sat_d   = sat_q | (clamp_x != sum_x);
    end

    // Saturation flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= clear_i ? 1'b0 : sat_d;
        end
    end

    assign sat_o = sat_q;
`else
    localparam int X_W = (ACC_W > P_W) ? ACC_W : P_W;

    logic [X_W-1:0] sum_w;

    // Plain modulo-2^ACC_W accumulation.
    always_comb begin
        sum_w = X_W'(acc_q) + X_W'(prod);
        acc_d = sum_w[ACC_W-1:0];
    end
`endif

    // Operand pass-through and accumulator registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= clear_i ? '0 : acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// Output-stationary N x N systolic multiplier, C = A x B, streamed.
// Optional macro: SYSTOLIC_SAT_EN (saturation and out_sat port).
module systolic_matmul_nxn
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = acc_width(N, DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   in_a,
    input  logic [N*DATA_W-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*ACC_W-1:0]    out_data,
    output logic [$clog2(N)-1:0]  out_row,
    output logic                  out_last,
`ifdef SYSTOLIC_SAT_EN
    output logic [N-1:0]          out_sat,
`endif
    output logic                  busy
);

    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N);

    state_e        state_q;
    state_e        state_d;
    logic [RW-1:0] beat_q;
    logic [RW-1:0] beat_d;
    logic [RW-1:0] row_q;
    logic [RW-1:0] row_d;
    logic [FW-1:0] fl_q;
    logic [FW-1:0] fl_d;
    logic          rdy_q;
    logic          rdy_d;
    logic          mode_q;
    logic          mode_d;

    logic accept;
    logic clear;
    logic mode_eff;

    logic [DATA_W-1:0] inj_a  [N];
    logic [DATA_W-1:0] inj_b  [N];
    logic [DATA_W-1:0] sk_a_q [N][N-1];
    logic [DATA_W-1:0] sk_b_q [N][N-1];
    logic [DATA_W-1:0] a_w    [N][N+1];
    logic [DATA_W-1:0] b_w    [N+1][N];
    logic [ACC_W-1:0]  acc_w  [N][N];
`ifdef SYSTOLIC_SAT_EN
    logic              sat_w  [N][N];
`endif

    assign accept = in_valid & rdy_q;
    assign clear  = (state_q == ST_DRAIN) & out_ready
                  & (row_q == RW'(N - 1));

    // The first beat's product meets PE(0,0) before the mode is latched.
    assign mode_eff = (accept && beat_q == '0) ? signed_mode : mode_q;

    // Next-state logic: load N beats, flush 2N-1 cycles, drain N rows.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        row_d   = row_q;
        fl_d    = fl_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (beat_q == '0) mode_d = signed_mode;
                    if (beat_q == RW'(N - 1)) begin
                        beat_d  = '0;
                        fl_d    = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        beat_d = beat_q + RW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (fl_q == FW'(2 * N - 2)) begin
                    state_d = ST_DRAIN;
                end else begin
                    fl_d = fl_q + FW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        beat_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
        rdy_d = (state_d == ST_LOAD);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            beat_q  <= '0;
            row_q   <= '0;
            fl_q    <= '0;
            rdy_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            fl_q    <= fl_d;
            rdy_q   <= rdy_d;
            mode_q  <= mode_d;
        end
    end

    // Idle cycles inject zeros so bubbles contribute nothing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inj_a[i] = accept ? in_a[i*DATA_W +: DATA_W] : '0;
            inj_b[i] = accept ? in_b[i*DATA_W +: DATA_W] : '0;
        end
    end

    // Skew shift chains; lane i is tapped at depth i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N - 1; d++) begin
                    sk_a_q[i][d] <= '0;
                    sk_b_q[i][d] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                sk_a_q[i][0] <= inj_a[i];
                sk_b_q[i][0] <= inj_b[i];
                for (int d = 1; d < N - 1; d++) begin
                    sk_a_q[i][d] <= sk_a_q[i][d-1];
                    sk_b_q[i][d] <= sk_b_q[i][d-1];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_edge
        if (i == 0) begin : g_d0
            assign a_w[0][0] = inj_a[0];
            assign b_w[0][0] = inj_b[0];
        end else begin : g_dn
            assign a_w[i][0] = sk_a_q[i][i-1];
            assign b_w[0][i] = sk_b_q[i][i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .clear_i (clear),
                .mode_i  (mode_eff),
                .a_i     (a_w[i][j]),
                .b_i     (b_w[i][j]),
                .a_o     (a_w[i][j+1]),
                .b_o     (b_w[i+1][j]),
`ifdef SYSTOLIC_SAT_EN
                .sat_o   (sat_w[i][j]),
`endif
                .acc_o   (acc_w[i][j])
            );
        end
    end

    // Present the selected accumulator row; zero outside DRAIN.
    always_comb begin
        out_valid = (state_q == ST_DRAIN);
        busy      = (state_q != ST_LOAD);
        out_row   = row_q;
        out_last  = out_valid & (row_q == RW'(N - 1));
        out_data  = '0;
`ifdef SYSTOLIC_SAT_EN
        out_sat   = '0;
`endif
        for (int j = 0; j < N; j++) begin
            if (out_valid) begin
                out_data[j*ACC_W +: ACC_W] = acc_w[row_q][j];
`ifdef SYSTOLIC_SAT_EN
                out_sat[j] = sat_w[row_q][j];
`endif
            end
        end
    end

    assign in_ready = rdy_q;

endmodule
